// File: rtl/pipe_pkg.sv
// Shared pipeline types for the MEM and WB stages.
// Widths, MEM FSM states, request latch and MEM/WB bundle.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [DATA_W-1:0] readdata;
        logic [DATA_W-1:0] aluout;
        logic [REG_W-1:0]  writereg;
        logic [31:0]       instr;
        logic              valid;
    } mem_wb_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic              memwrite;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [REG_W-1:0]  writereg;
        logic [31:0]       instr;
    } mem_req_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Bubble clears every field; load captures the next bundle.
module mem_wb_reg
    import pipe_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    load,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    // Bubble wins over load so an aborted access never leaks into WB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data-memory req/ack handshake, pipeline stall,
// timeout abort and the MEM/WB pipeline register.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int DW          = DATA_W,
    parameter int RW          = REG_W,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          regwriteM,
    input  logic          memtoregM,
    input  logic          memwriteM,
    input  logic [DW-1:0] aluoutM,
    input  logic [DW-1:0] writedataM,
    input  logic [RW-1:0] writeregM,
    input  logic [31:0]   instrM,
    output logic          stallM,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          regwriteW,
    output logic          memtoregW,
    output logic [DW-1:0] readdataW,
    output logic [DW-1:0] aluoutW,
    output logic [RW-1:0] writeregW,
    output logic [31:0]   instrW,
    output logic          validW,
    output logic          misalign_err,
    output logic          bus_err
);

    localparam int            CW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    mem_state_t    state;
    logic [CW-1:0] cnt;
    mem_req_t      req_m;
    mem_req_t      req_q;
    mem_req_t      req_sel;
    mem_wb_t       w_d;
    mem_wb_t       w_q;
    logic          mem_op;
    logic          misaligned;
    logic          issue;
    logic          in_wait;
    logic          timeout;
    logic          done;
    logic          w_load;

    assign mem_op     = memtoregM | memwriteM;
    assign misaligned = mem_op & (aluoutM[1:0] != 2'b00);
    assign issue      = (state == IDLE) & mem_op & ~misaligned;
    assign in_wait    = (state == WAIT);
    assign timeout    = in_wait & (cnt == CNT_LAST);

    // Request fields straight from EX/MEM, or the copy held across WAIT.
    always_comb begin
        req_m          = '0;
        req_m.regwrite = regwriteM;
        req_m.memtoreg = memtoregM;
        req_m.memwrite = memwriteM;
        req_m.addr     = aluoutM;
        req_m.wdata    = writedataM;
        req_m.writereg = writeregM;
        req_m.instr    = instrM;
        req_sel        = in_wait ? req_q : req_m;
    end

    // Reset gates the handshake so an aborted access drops at once.
    assign dmem_req   = reset_n & (issue | (in_wait & ~timeout));
    assign stallM     = dmem_req & ~dmem_ack;
    assign dmem_we    = dmem_req & req_sel.memwrite;
    assign dmem_addr  = req_sel.addr;
    assign dmem_wdata = req_sel.wdata;

    assign done   = dmem_req & dmem_ack;
    assign w_load = ((state == IDLE) & ~mem_op) | done;

    // Next WB bundle; stores never write the register file.
    always_comb begin
        w_d          = '0;
        w_d.regwrite = req_sel.regwrite & ~req_sel.memwrite;
        w_d.memtoreg = req_sel.memtoreg;
        w_d.readdata = req_sel.memtoreg ? dmem_rdata : '0;
        w_d.aluout   = req_sel.addr;
        w_d.writereg = req_sel.writereg;
        w_d.instr    = req_sel.instr;
        w_d.valid    = 1'b1;
    end

    // FSM, request latch, timeout counter and error pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            req_q        <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= (state == IDLE) & misaligned;
            bus_err      <= timeout;
            unique case (state)
                IDLE: begin
                    if (issue & ~dmem_ack) begin
                        state <= WAIT;
                        req_q <= req_m;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (timeout | dmem_ack) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    mem_wb_reg u_wreg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_load),
        .bubble  (~w_load),
        .d       (w_d),
        .q       (w_q)
    );

    assign regwriteW = w_q.regwrite;
    assign memtoregW = w_q.memtoreg;
    assign readdataW = w_q.readdata;
    assign aluoutW   = w_q.aluout;
    assign writeregW = w_q.writereg;
    assign instrW    = w_q.instr;
    assign validW    = w_q.valid;

endmodule
